line_window_feeder: RTL and testbench

- Raster-to-column converter that drives the 3x3 convolution engine.
- Accepts one pixel per clock in raster order and stores the two previous image rows in on-chip line buffers.
- Emits three vertically aligned pixels per clock, oldest row first, as the top/mid/bot column stream the convolution engine shifts into its window.
- Also emits window position and framing flags so downstream logic can discard border windows.

---
 rtl/line_window_feeder.sv | 171 +++++++++++++++++
 tb/tb_line_window_feeder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/line_window_feeder.sv
// line_window_feeder
// Raster-to-column converter for a 3x3 convolution engine. Pixels arrive one
// per clock in raster order. Two line buffers hold the two previous rows, and
// each streamed pixel emits one vertically aligned column (oldest row first)
// together with its position and framing flags.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_valid        in_pixel is valid this cycle
//   in_sof          first pixel of a frame (qualified by in_valid)
//   in_pixel        raster input pixel
//   pix_top/mid/bot pixels at (row-2,col), (row-1,col), (row,col)
//   out_valid       column outputs valid (registered, latency 1)
//   out_col/out_row column index and center row (row-1) of the emitted column
//   out_eol/out_eof last column of a row / of the frame
//   sync_err        one-cycle pulse per framing-violation input beat
module line_window_feeder #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int COLW        = 10,
  parameter int ROWW        = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic [PIXEL_WIDTH-1:0] pix_top,
  output logic [PIXEL_WIDTH-1:0] pix_mid,
  output logic [PIXEL_WIDTH-1:0] pix_bot,
  output logic                   out_valid,
  output logic [COLW-1:0]        out_col,
  output logic [ROWW-1:0]        out_row,
  output logic                   out_eol,
  output logic                   out_eof,
  output logic                   sync_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [COLW-1:0]        col_r, col_s;
  logic [ROWW-1:0]        row_r, row_s;

  // Line buffers: lb_b_r holds row r-1, lb_a_r holds row r-2. Not reset.
  logic [PIXEL_WIDTH-1:0] lb_a_r [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb_b_r [IMG_WIDTH];

  logic                   sof_s;
  logic                   accept_s;
  logic                   emit_s;
  logic                   err_s;
  logic                   last_col_s;
  logic                   last_row_s;
  logic [COLW-1:0]        wr_col_s;

  // Beat qualification: acceptance, emission, violations and write column.
  always_comb begin
    sof_s      = in_valid & in_sof;
    accept_s   = in_valid & (in_sof | (state_r != IDLE));
    // An sof beat restarts the frame, so it never produces a column.
    emit_s     = in_valid & ~in_sof & (state_r == STREAM);
    err_s      = in_valid & (((state_r == IDLE) & ~in_sof) |
                             ((state_r != IDLE) & in_sof));
    last_col_s = (col_r == COLW'(IMG_WIDTH - 1));
    last_row_s = (row_r == ROWW'(IMG_HEIGHT - 1));
    if (sof_s) begin
      wr_col_s = {COLW{1'b0}};
    end else begin
      wr_col_s = col_r;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      col_r   <= {COLW{1'b0}};
      row_r   <= {ROWW{1'b0}};
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      row_r   <= row_s;
    end
  end

  // Next-state and counter logic; in_valid=0 holds everything.
  always_comb begin
    state_s = state_r;
    col_s   = col_r;
    row_s   = row_r;
    if (sof_s) begin
      // The sof pixel itself occupies column 0, so the next one is column 1.
      state_s = FILL;
      col_s   = COLW'(1);
      row_s   = {ROWW{1'b0}};
    end else if (accept_s) begin
      if (last_col_s) begin
        col_s = {COLW{1'b0}};
        row_s = row_r + ROWW'(1);
      end else begin
        col_s = col_r + COLW'(1);
        row_s = row_r;
      end
      case (state_r)
        FILL: begin
          if (last_col_s && (row_r == ROWW'(1))) begin
            state_s = STREAM;
          end else begin
            state_s = FILL;
          end
        end
        STREAM: begin
          if (last_col_s && last_row_s) begin
            state_s = IDLE;
            col_s   = {COLW{1'b0}};
            row_s   = {ROWW{1'b0}};
          end else begin
            state_s = STREAM;
          end
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Line buffer update: shift the column up one row and store the new pixel.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb_a_r[wr_col_s] <= lb_b_r[wr_col_s];
      lb_b_r[wr_col_s] <= in_pixel;
    end
  end

  // Registered outputs; data and position hold when nothing is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_top   <= {PIXEL_WIDTH{1'b0}};
      pix_mid   <= {PIXEL_WIDTH{1'b0}};
      pix_bot   <= {PIXEL_WIDTH{1'b0}};
      out_valid <= 1'b0;
      out_col   <= {COLW{1'b0}};
      out_row   <= {ROWW{1'b0}};
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= emit_s;
      out_eol   <= emit_s & last_col_s;
      out_eof   <= emit_s & last_col_s & last_row_s;
      sync_err  <= err_s;
      if (emit_s) begin
        pix_top <= lb_a_r[col_r];
        pix_mid <= lb_b_r[col_r];
        pix_bot <= in_pixel;
        out_col <= col_r;
        out_row <= row_r - ROWW'(1);
      end
    end
  end

endmodule

// File: tb/tb_line_window_feeder.sv
// Scoreboard bench for line_window_feeder on a 4x4 image. Stimulus pushes the
// expected column for every streamed pixel; a negedge monitor pops and
// compares whenever out_valid is high.
module tb_line_window_feeder;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CW = 2;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PW-1:0] in_pixel = 8'd0;
  logic [PW-1:0] pix_top, pix_mid, pix_bot;
  logic          out_valid, out_eol, out_eof, sync_err;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;

  typedef struct packed {
    logic [PW-1:0] top;
    logic [PW-1:0] mid;
    logic [PW-1:0] bot;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          eol;
    logic          eof;
  } col_t;

  col_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   sync_cnt = 0;
  int   valid_cnt = 0;

  line_window_feeder #(
    .PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COLW(CW), .ROWW(RW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .pix_top(pix_top), .pix_mid(pix_mid),
    .pix_bot(pix_bot), .out_valid(out_valid), .out_col(out_col),
    .out_row(out_row), .out_eol(out_eol), .out_eof(out_eof),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Monitor: compare each emitted column against the scoreboard head.
  always @(negedge clk) begin
    col_t act;
    col_t exp;
    if (sync_err) sync_cnt++;
    if (out_valid) begin
      valid_cnt++;
      act = '{pix_top, pix_mid, pix_bot, out_col, out_row, out_eol, out_eof};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL column: unexpected beat got %h, none expected", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL column: got top=%0d mid=%0d bot=%0d col=%0d row=%0d eol=%b eof=%b, want top=%0d mid=%0d bot=%0d col=%0d row=%0d eol=%b eof=%b",
                   act.top, act.mid, act.bot, act.col, act.row, act.eol, act.eof,
                   exp.top, exp.mid, exp.bot, exp.col, exp.row, exp.eol, exp.eof);
        end
      end
    end else if (out_eol || out_eof) begin
      checks++;
      errors++;
      $display("FAIL flags_idle: got eol=%b eof=%b, want 0 0", out_eol, out_eof);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic beat(input logic v, input logic sof, input logic [PW-1:0] p);
    in_valid = v;
    in_sof   = sof;
    in_pixel = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) beat(1'b0, 1'b0, 8'd0);
  endtask

  // Pixel i of a frame has value base+i; streamed pixels (i>=8) push the
  // column (base+i-8, base+i-4, base+i) at col i%4, center row i/4-1.
  task automatic send_frame(input int base, input int n, input bit gap);
    col_t e;
    for (int i = 0; i < n; i++) begin
      if (i >= 2 * W) begin
        e.top = PW'(base + i - 2 * W);
        e.mid = PW'(base + i - W);
        e.bot = PW'(base + i);
        e.col = CW'(i % W);
        e.row = RW'(i / W - 1);
        e.eol = ((i % W) == W - 1);
        e.eof = (i == W * H - 1);
        exp_q.push_back(e);
      end
      beat(1'b1, (i == 0), PW'(base + i));
      if (gap) idle(2);
    end
  endtask

  task automatic drain(input string name);
    int s0;
    idle(3);
    check({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int s0;
    int v0;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    int v0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_top", pix_top, 0);
    check("reset_sync", sync_err, 0);
    rst = 1'b0;
    idle(1);

    // Basic frame: 8 beats, first (0,4,8) row1 col0, last (7,11,15) eol/eof.
    s0 = sync_cnt; v0 = valid_cnt;
    send_frame(0, 16, 1'b0);
    drain("basic");
    check("basic_beats", valid_cnt - v0, 8);
    check("basic_sync", sync_cnt - s0, 0);

    // Gapped frame.
    s0 = sync_cnt; v0 = valid_cnt;
    send_frame(20, 16, 1'b1);
    drain("gapped");
    check("gapped_beats", valid_cnt - v0, 8);
    check("gapped_sync", sync_cnt - s0, 0);

    // Mid-frame restart: sof again on pixel 10.
    s0 = sync_cnt; v0 = valid_cnt;
    send_frame(40, 10, 1'b0);
    send_frame(60, 16, 1'b0);
    drain("restart");
    check("restart_sync", sync_cnt - s0, 1);
    check("restart_beats", valid_cnt - v0, 10);

    // No-sof stream from reset.
    rst = 1'b1; idle(1); rst = 1'b0;
    s0 = sync_cnt; v0 = valid_cnt;
    for (int k = 0; k < 5; k++) beat(1'b1, 1'b0, PW'(k + 1));
    idle(2);
    check("nosof_sync", sync_cnt - s0, 5);
    check("nosof_beats", valid_cnt - v0, 0);

    // Async reset while streaming, at pixel 12.
    send_frame(80, 12, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    in_valid = 1'b1; in_pixel = 8'd92;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_top", pix_top, 0);
    check("arst_mid", pix_mid, 0);
    check("arst_bot", pix_bot, 0);
    check("arst_col_row", {out_col, out_row}, 0);
    check("arst_flags", {out_eol, out_eof, sync_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("arst_queue", exp_q.size(), 0);
    v0 = valid_cnt;
    for (int k = 0; k < 6; k++) beat(1'b1, 1'b0, PW'(93 + k));
    idle(2);
    check("arst_ignored", valid_cnt - v0, 0);
    s0 = sync_cnt; v0 = valid_cnt;
    send_frame(100, 16, 1'b0);
    drain("after_rst");
    check("after_rst_beats", valid_cnt - v0, 8);

    // Back-to-back frames.
    s0 = sync_cnt; v0 = valid_cnt;
    send_frame(120, 16, 1'b0);
    send_frame(140, 16, 1'b0);
    drain("b2b");
    check("b2b_sync", sync_cnt - s0, 0);
    check("b2b_beats", valid_cnt - v0, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
